// File: rtl/axil_led_regs.sv
// axil_led_regs
// AXI4-Lite register block for the PS GP0 LED window. Software writes
// LED_DATA to drive led_o, and can exercise the bus through a scratch
// register, a free-running cycle counter and a constant ID word.
//
// Register map (word offsets, addr[1:0] ignored):
//   0x0 LED_DATA  RW  only [LED_WIDTH-1:0] stored, upper bits read 0
//   0x4 SCRATCH   RW  32 bit
//   0x8 CYCLE_CNT RO  free-running, wraps
//   0xC ID        RO  ID_VALUE
//   >= 0x10       unmapped, SLVERR on read and write
//
// Ports:
//   ACLK, ARESETn        clock, async active-low reset
//   S_AXI_AW*/W*/B*      write address, data and response channels
//   S_AXI_AR*/R*         read address and data channels
//   led_o                LED drive, mirrors LED_DATA[LED_WIDTH-1:0]
module axil_led_regs #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          LED_WIDTH  = 4,
    parameter logic [31:0] ID_VALUE   = 32'h4C45_4401
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [LED_WIDTH-1:0]  led_o
);

    localparam int WAW = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t              w_state;
    r_state_t              r_state;
    logic                  aw_ready_q, w_ready_q, ar_ready_q;
    logic                  b_valid_q, r_valid_q;
    logic [1:0]            b_resp_q, r_resp_q;
    logic [31:0]           r_data_q;
    logic [WAW-1:0]        aw_word_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;
    logic [LED_WIDTH-1:0]  led_q;
    logic [31:0]           scratch_q;
    logic [31:0]           cycle_cnt_q;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  commit, commit_rw;
    logic [WAW-1:0]        commit_word;
    logic [31:0]           commit_data, commit_mask;
    logic [3:0]            commit_strb;
    logic [WAW-1:0]        ar_word;
    logic [31:0]           led_word, rd_data;
    logic                  rd_ok;
    logic                  unused_inputs;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = w_ready_q;
    assign S_AXI_BVALID  = b_valid_q;
    assign S_AXI_BRESP   = b_resp_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = r_valid_q;
    assign S_AXI_RRESP   = r_resp_q;
    assign S_AXI_RDATA   = r_data_q;
    assign led_o         = led_q;

    assign aw_hs   = S_AXI_AWVALID & aw_ready_q;
    assign w_hs    = S_AXI_WVALID  & w_ready_q;
    assign ar_hs   = S_AXI_ARVALID & ar_ready_q;
    assign ar_word = S_AXI_ARADDR[ADDR_WIDTH-1:2];

    // The commit happens on whichever edge completes the AW/W pair. The
    // half already held in a register is used, the other half comes
    // straight from the bus, so a write commits on the same edge its last
    // beat is accepted.
    always_comb begin
        commit      = 1'b0;
        commit_word = S_AXI_AWADDR[ADDR_WIDTH-1:2];
        commit_data = S_AXI_WDATA;
        commit_strb = S_AXI_WSTRB;
        case (w_state)
            W_IDLE:    commit = aw_hs & w_hs;
            W_HAVE_AW: begin
                commit      = w_hs;
                commit_word = aw_word_q;
            end
            W_HAVE_W:  begin
                commit      = aw_hs;
                commit_data = w_data_q;
                commit_strb = w_strb_q;
            end
            default:   commit = 1'b0;
        endcase
        // Only word offsets 0 and 1 are writable.
        commit_rw   = (commit_word[WAW-1:1] == '0);
        commit_mask = {{8{commit_strb[3]}}, {8{commit_strb[2]}},
                       {8{commit_strb[1]}}, {8{commit_strb[0]}}};
    end

    // Write channel FSM. Readiness is registered so that all three ready
    // signals sit low in reset and rise on the first edge after release;
    // an idle FSM with its readies low is exactly that post-reset case.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state    <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            aw_word_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (commit) begin
                        w_state    <= W_RESP;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                        b_valid_q  <= 1'b1;
                        b_resp_q   <= commit_rw ? RESP_OKAY : RESP_SLVERR;
                    end else if (aw_hs) begin
                        w_state    <= W_HAVE_AW;
                        aw_ready_q <= 1'b0;
                        aw_word_q  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
                    end else if (w_hs) begin
                        w_state   <= W_HAVE_W;
                        w_ready_q <= 1'b0;
                        w_data_q  <= S_AXI_WDATA;
                        w_strb_q  <= S_AXI_WSTRB;
                    end else begin
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                    end
                end
                W_HAVE_AW, W_HAVE_W: begin
                    if (commit) begin
                        w_state    <= W_RESP;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                        b_valid_q  <= 1'b1;
                        b_resp_q   <= commit_rw ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                default: begin
                    if (S_AXI_BREADY) begin
                        w_state    <= W_IDLE;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        b_valid_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Writable registers. Byte strobes are expanded to a bit mask so the
    // LED register simply takes the low LED_WIDTH bits of the merge.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            led_q     <= '0;
            scratch_q <= '0;
        end else if (commit && commit_rw) begin
            if (commit_word[0] == 1'b0)
                led_q <= (led_q & ~commit_mask[LED_WIDTH-1:0]) |
                         (commit_data[LED_WIDTH-1:0] & commit_mask[LED_WIDTH-1:0]);
            else
                scratch_q <= (scratch_q & ~commit_mask) | (commit_data & commit_mask);
        end
    end

    // Free-running cycle counter, wraps naturally at 32 bits.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            cycle_cnt_q <= '0;
        else
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end

    // Read mux works on the current register values, so a read on the same
    // edge as a write commit sees the pre-write contents.
    always_comb begin
        led_word                  = '0;
        led_word[LED_WIDTH-1:0]   = led_q;
        rd_data                   = '0;
        rd_ok                     = 1'b0;
        if (ar_word[WAW-1:2] == '0) begin
            rd_ok = 1'b1;
            case (ar_word[1:0])
                2'd0:    rd_data = led_word;
                2'd1:    rd_data = scratch_q;
                2'd2:    rd_data = cycle_cnt_q;
                default: rd_data = ID_VALUE;
            endcase
        end
    end

    // Read channel FSM: accept one AR, hold the registered response until
    // the master takes it, then reopen ARREADY.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state    <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_resp_q   <= RESP_OKAY;
            r_data_q   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state    <= R_RESP;
                        ar_ready_q <= 1'b0;
                        r_valid_q  <= 1'b1;
                        r_data_q   <= rd_data;
                        r_resp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        ar_ready_q <= 1'b1;
                    end
                end
                default: begin
                    if (S_AXI_RREADY) begin
                        r_state    <= R_IDLE;
                        ar_ready_q <= 1'b1;
                        r_valid_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_led_regs.sv
// tb_axil_led_regs
// Self-checking bench for axil_led_regs. Directed transactions cover the
// register map, strobes, AW/W ordering, error responses, the cycle counter
// and reset mid-transaction; a randomized phase compares every response
// against a register-level model of the map.
module tb_axil_led_regs;

    localparam int          ADDR_WIDTH = 12;
    localparam int          LED_WIDTH  = 4;
    localparam logic [31:0] ID_VALUE   = 32'h4C45_4401;
    localparam logic [31:0] LED_MASK   = (32'd1 << LED_WIDTH) - 32'd1;

    logic                  tb_ACLK = 1'b0;
    logic                  tb_ARESETn = 1'b0;
    logic [ADDR_WIDTH-1:0] S_AXI_AWADDR = '0;
    logic [2:0]            S_AXI_AWPROT = '0;
    logic                  S_AXI_AWVALID = 1'b0;
    logic                  S_AXI_AWREADY;
    logic [31:0]           S_AXI_WDATA = '0;
    logic [3:0]            S_AXI_WSTRB = '0;
    logic                  S_AXI_WVALID = 1'b0;
    logic                  S_AXI_WREADY;
    logic [1:0]            S_AXI_BRESP;
    logic                  S_AXI_BVALID;
    logic                  S_AXI_BREADY = 1'b0;
    logic [ADDR_WIDTH-1:0] S_AXI_ARADDR = '0;
    logic [2:0]            S_AXI_ARPROT = '0;
    logic                  S_AXI_ARVALID = 1'b0;
    logic                  S_AXI_ARREADY;
    logic [31:0]           S_AXI_RDATA;
    logic [1:0]            S_AXI_RRESP;
    logic                  S_AXI_RVALID;
    logic                  S_AXI_RREADY = 1'b0;
    logic [LED_WIDTH-1:0]  led_o;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_led = '0;
    logic [31:0] model_scratch = '0;

    axil_led_regs #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LED_WIDTH  (LED_WIDTH),
        .ID_VALUE   (ID_VALUE)
    ) dut (
        .ACLK          (tb_ACLK),
        .ARESETn       (tb_ARESETn),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .led_o         (led_o)
    );

    // 100 MHz-style free-running clock.
    always #5 tb_ACLK = ~tb_ACLK;

    // Hard stop in case a handshake loop somehow never terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Byte-lane merge used by the reference model.
    function automatic logic [31:0] mergeLanes(input logic [31:0] old_val, input logic [31:0] new_val, input logic [3:0] strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        return res;
    endfunction

    // Reference model of a write: update state, return the expected BRESP.
    task automatic modelWrite(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb, output logic [1:0] resp);
        int word;
        word = int'(addr) / 4;
        resp = 2'b10;
        if (word == 0) begin
            model_led = mergeLanes(model_led, data, strb) & LED_MASK;
            resp = 2'b00;
        end else if (word == 1) begin
            model_scratch = mergeLanes(model_scratch, data, strb);
            resp = 2'b00;
        end
    endtask

    // Reference model of a read. The counter value is not predicted here.
    task automatic modelRead(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp, output bit data_known);
        int word;
        word = int'(addr) / 4;
        data = 32'h0;
        resp = 2'b00;
        data_known = 1'b1;
        case (word)
            0: data = model_led;
            1: data = model_scratch;
            2: data_known = 1'b0;
            3: data = ID_VALUE;
            default: resp = 2'b10;
        endcase
    endtask

    // Drive one write with independent AW and W delays, then hold BREADY
    // low for b_dly cycles while offering a second AW that must be refused.
    task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                 input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        int cyc;
        bit aw_done, w_done, aw_hit, w_hit;
        cyc = 0; aw_done = 0; w_done = 0; resp = 2'b11;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        while (!(aw_done && w_done) && cyc < 64) begin
            @(negedge tb_ACLK);
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done && (cyc >= w_dly);
            #1;
            if (aw_done && !w_done) begin
                checkOutput("wready_after_aw", 32'(S_AXI_WREADY), 32'd1);
                checkOutput("awready_after_aw", 32'(S_AXI_AWREADY), 32'd0);
            end
            if (w_done && !aw_done) begin
                checkOutput("awready_after_w", 32'(S_AXI_AWREADY), 32'd1);
                checkOutput("wready_after_w", 32'(S_AXI_WREADY), 32'd0);
            end
            aw_hit = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hit  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge tb_ACLK);
            aw_done = aw_done || aw_hit;
            w_done  = w_done || w_hit;
            cyc++;
        end
        @(negedge tb_ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        #1;
        checkOutput("write_accept", {30'd0, aw_done, w_done}, 32'd3);
        if (!(aw_done && w_done)) return;
        checkOutput("b_latency", 32'(S_AXI_BVALID), 32'd1);
        for (int i = 0; i < b_dly; i++) begin
            S_AXI_AWVALID = 1'b1;
            @(posedge tb_ACLK);
            @(negedge tb_ACLK);
            #1;
            checkOutput("b_hold", 32'(S_AXI_BVALID), 32'd1);
            checkOutput("no_second_aw", 32'(S_AXI_AWREADY), 32'd0);
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_BREADY  = 1'b1;
        resp = S_AXI_BRESP;
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        S_AXI_BREADY = 1'b0;
        #1;
        checkOutput("b_release", 32'(S_AXI_BVALID), 32'd0);
        checkOutput("awready_back", 32'(S_AXI_AWREADY), 32'd1);
    endtask

    // Drive one read, delay RREADY by r_dly cycles and check the response
    // stays stable while pending.
    task automatic applyRead(input logic [11:0] addr, input int r_dly, output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        bit hit, h;
        cyc = 0; hit = 0;
        data = '0; resp = 2'b11;
        S_AXI_ARADDR = addr;
        while (!hit && cyc < 64) begin
            @(negedge tb_ACLK);
            S_AXI_ARVALID = 1'b1;
            #1;
            h = S_AXI_ARREADY;
            @(posedge tb_ACLK);
            hit = h;
            cyc++;
        end
        @(negedge tb_ACLK);
        S_AXI_ARVALID = 1'b0;
        #1;
        checkOutput("ar_accept", 32'(hit), 32'd1);
        if (!hit) return;
        checkOutput("r_latency", 32'(S_AXI_RVALID), 32'd1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        for (int i = 0; i < r_dly; i++) begin
            @(posedge tb_ACLK);
            @(negedge tb_ACLK);
            #1;
            checkOutput("r_hold", 32'(S_AXI_RVALID), 32'd1);
            checkOutput("r_data_stable", S_AXI_RDATA, data);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        S_AXI_RREADY = 1'b0;
        #1;
        checkOutput("r_release", 32'(S_AXI_RVALID), 32'd0);
    endtask

    // Full write + read check against the model.
    task automatic writeChecked(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] got, exp;
        applyStimulus(addr, data, strb, aw_dly, w_dly, b_dly, got);
        modelWrite(addr, data, strb, exp);
        checkOutput("bresp", 32'(got), 32'(exp));
        checkOutput("led_o", 32'(led_o), model_led);
    endtask

    task automatic readChecked(input logic [11:0] addr, input int r_dly);
        logic [31:0] got_d, exp_d;
        logic [1:0]  got_r, exp_r;
        bit          known;
        applyRead(addr, r_dly, got_d, got_r);
        modelRead(addr, exp_d, exp_r, known);
        checkOutput("rresp", 32'(got_r), 32'(exp_r));
        if (known) checkOutput("rdata", got_d, exp_d);
    endtask

    function automatic logic [11:0] randAddr();
        int sel;
        logic [11:0] a;
        sel = $urandom_range(0, 5);
        if (sel < 4)       a = 12'(sel * 4 + $urandom_range(0, 3));
        else if (sel == 4) a = 12'(16 + 4 * $urandom_range(0, 1019));
        else               a = 12'($urandom_range(0, 4095));
        return a;
    endfunction

    initial begin
        logic [31:0] c0, c1;

        // Reset state.
        repeat (3) @(posedge tb_ACLK);
        #1;
        checkOutput("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        checkOutput("rst_wready", 32'(S_AXI_WREADY), 32'd0);
        checkOutput("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        checkOutput("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        checkOutput("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        checkOutput("rst_rdata", S_AXI_RDATA, 32'd0);
        checkOutput("rst_resp", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
        checkOutput("rst_led", 32'(led_o), 32'd0);
        @(negedge tb_ACLK);
        tb_ARESETn = 1'b1;
        #1;
        checkOutput("pre_edge_awready", 32'(S_AXI_AWREADY), 32'd0);
        @(posedge tb_ACLK);
        #1;
        checkOutput("rel_readies", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);

        // Register map basics and byte strobes.
        writeChecked(12'h000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        checkOutput("led_all_on", 32'(led_o), 32'h0000_000F);
        readChecked(12'h000, 0);
        writeChecked(12'h004, 32'hDEAD_BEEF, 4'hF, 0, 0, 1);
        readChecked(12'h004, 1);
        writeChecked(12'h004, 32'h1122_3344, 4'h5, 0, 0, 0);
        readChecked(12'h004, 0);
        checkOutput("strb_merge_model", model_scratch, 32'hDE22_BE44);
        writeChecked(12'h004, 32'h0BAD_F00D, 4'h0, 0, 0, 0);
        readChecked(12'h004, 0);

        // AW three cycles ahead of W, B held off for five cycles.
        writeChecked(12'h000, 32'h0000_0005, 4'h1, 0, 3, 5);
        // W ahead of AW.
        writeChecked(12'h004, 32'hCAFE_0001, 4'hF, 2, 0, 0);
        readChecked(12'h000, 0);

        // Error responses; state must not move.
        writeChecked(12'h008, 32'h1234_5678, 4'hF, 0, 0, 0);
        writeChecked(12'h00C, 32'h1234_5678, 4'hF, 1, 0, 0);
        writeChecked(12'h020, 32'h1234_5678, 4'hF, 0, 0, 0);
        readChecked(12'h020, 0);
        readChecked(12'h000, 0);
        readChecked(12'h004, 0);
        readChecked(12'h00C, 0);

        // Two counter reads with AR handshakes exactly ten edges apart.
        @(negedge tb_ACLK);
        S_AXI_ARADDR = 12'h008; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        #1;
        checkOutput("cnt_ar_ready0", 32'(S_AXI_ARREADY), 32'd1);
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        S_AXI_ARVALID = 1'b0;
        #1;
        checkOutput("cnt_rvalid0", 32'(S_AXI_RVALID), 32'd1);
        c0 = S_AXI_RDATA;
        repeat (9) @(negedge tb_ACLK);
        S_AXI_ARVALID = 1'b1;
        #1;
        checkOutput("cnt_ar_ready1", 32'(S_AXI_ARREADY), 32'd1);
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        S_AXI_ARVALID = 1'b0;
        #1;
        checkOutput("cnt_rvalid1", 32'(S_AXI_RVALID), 32'd1);
        c1 = S_AXI_RDATA;
        checkOutput("cnt_delta", c1 - c0, 32'd10);
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        S_AXI_RREADY = 1'b0;

        // Randomized traffic against the model, including overlapped
        // read/write pairs on unrelated registers.
        for (int n = 0; n < 40; n++) begin
            int op;
            logic [11:0] wa, ra;
            logic [31:0] wd;
            logic [3:0]  ws;
            op = $urandom_range(0, 2);
            wa = randAddr();
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            if (op == 0) begin
                writeChecked(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else if (op == 1) begin
                readChecked(randAddr(), $urandom_range(0, 2));
            end else begin
                ra = ($urandom_range(0, 1) == 0) ? 12'h00C : 12'h040;
                fork
                    writeChecked(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
                    readChecked(ra, $urandom_range(0, 2));
                join
            end
        end
        readChecked(12'h000, 0);
        readChecked(12'h004, 0);

        // Reset while a write response is pending.
        @(negedge tb_ACLK);
        S_AXI_AWADDR = 12'h000; S_AXI_WDATA = 32'h0000_000A; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(posedge tb_ACLK);
        @(negedge tb_ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        #1;
        checkOutput("pend_bvalid", 32'(S_AXI_BVALID), 32'd1);
        checkOutput("pend_led", 32'(led_o), 32'h0000_000A);
        tb_ARESETn = 1'b0;
        #1;
        checkOutput("arst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        checkOutput("arst_led", 32'(led_o), 32'd0);
        checkOutput("arst_readies", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
        model_led = '0;
        model_scratch = '0;
        @(negedge tb_ACLK);
        tb_ARESETn = 1'b1;
        #1;
        checkOutput("rel2_pre_edge", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
        @(posedge tb_ACLK);
        #1;
        checkOutput("rel2_readies", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd7);
        readChecked(12'h004, 0);
        readChecked(12'h000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
